aes_decipher_ctrl: RTL and testbench

Sequencer for the combinational decipher round datapath (`aes_decipher_round`). It holds the 128-bit working block in a register and steps the datapath through one initial round, Nr−1 main rounds and one final round, one round per clock. It drives the round type and the round-key address toward the key memory, and returns the plaintext with a ready/valid handshake. It sits between the core's top-level command interface and the decipher datapath.

---
 rtl/aes_decipher_ctrl.sv | 123 ++++++++++++
 tb/tb_aes_decipher_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decipher_ctrl.sv
// rtl/aes_decipher_ctrl.sv - round sequencer for the combinational AES decipher datapath
// Steps INIT, Nr-1 MAIN and FINAL rounds one per clock and returns the plaintext.
module aes_decipher_ctrl (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_next,
  input  logic         i_abort,
  input  logic [1:0]   i_keylen,
  input  logic         i_key_ready,
  input  logic [127:0] i_block,
  output logic [1:0]   o_round_type,
  output logic [3:0]   o_round_key_addr,
  output logic [127:0] o_dp_block,
  input  logic [127:0] i_dp_new_block,
  output logic         o_ready,
  output logic [127:0] o_result,
  output logic         o_result_valid,
  output logic         o_error
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_MAIN, S_FINAL} state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic [3:0]   r_round_ctr;
  logic [3:0]   r_nr;
  logic [127:0] r_block;
  logic         r_result_valid;
  logic         r_error;
  logic         w_start_ok;
  logic [3:0]   w_nr_sel;

  assign w_start_ok = i_next && i_key_ready && (i_keylen != 2'b11);

  always_comb begin
    case (i_keylen)
      2'b00:   w_nr_sel = 4'd10;
      2'b01:   w_nr_sel = 4'd12;
      default: w_nr_sel = 4'd14;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next_state = S_INIT;
      S_INIT:  w_next_state = i_abort ? S_IDLE : S_MAIN;
      S_MAIN:  begin
        if (i_abort)                 w_next_state = S_IDLE;
        else if (r_round_ctr == 4'd1) w_next_state = S_FINAL;
      end
      S_FINAL: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_round_type     = 2'd3;
    o_round_key_addr = 4'd0;
    case (r_state)
      S_INIT:  begin o_round_type = 2'd0; o_round_key_addr = r_round_ctr; end
      S_MAIN:  begin o_round_type = 2'd1; o_round_key_addr = r_round_ctr; end
      S_FINAL: begin o_round_type = 2'd2; o_round_key_addr = 4'd0;        end
      default: begin o_round_type = 2'd3; o_round_key_addr = 4'd0;        end
    endcase
  end

  // An aborted round leaves the working block untouched; its contents are discarded anyway.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_round_ctr    <= 4'd0;
      r_nr           <= 4'd0;
      r_block        <= 128'd0;
      r_result_valid <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_error        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_block     <= i_block;
            r_nr        <= w_nr_sel;
            r_round_ctr <= w_nr_sel;
          end else if (i_next) begin
            r_error <= 1'b1;
          end
        end
        S_INIT: begin
          if (!i_abort) begin
            r_block     <= i_dp_new_block;
            r_round_ctr <= r_nr - 4'd1;
          end
        end
        S_MAIN: begin
          if (!i_abort) begin
            r_block <= i_dp_new_block;
            if (r_round_ctr != 4'd0) r_round_ctr <= r_round_ctr - 4'd1;
          end
        end
        S_FINAL: begin
          if (!i_abort) begin
            r_block        <= i_dp_new_block;
            r_result_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready        = (r_state == S_IDLE);
  assign o_dp_block     = r_block;
  assign o_result       = r_block;
  assign o_result_valid = r_result_valid;
  assign o_error        = r_error;

endmodule

// File: tb/tb_aes_decipher_ctrl.sv
// tb/tb_aes_decipher_ctrl.sv - self-checking bench for aes_decipher_ctrl with a behavioural AES round model
module tb_aes_decipher_ctrl;

  logic         clk = 1'b0;
  logic         i_reset, i_next, i_abort, i_key_ready;
  logic [1:0]   i_keylen;
  logic [127:0] i_block, i_dp_new_block;
  logic [1:0]   o_round_type;
  logic [3:0]   o_round_key_addr;
  logic [127:0] o_dp_block, o_result;
  logic         o_ready, o_result_valid, o_error;

  always #5 clk = ~clk;

  aes_decipher_ctrl dut (
    .i_clk(clk), .i_reset(i_reset), .i_next(i_next), .i_abort(i_abort),
    .i_keylen(i_keylen), .i_key_ready(i_key_ready), .i_block(i_block),
    .o_round_type(o_round_type), .o_round_key_addr(o_round_key_addr),
    .o_dp_block(o_dp_block), .i_dp_new_block(i_dp_new_block),
    .o_ready(o_ready), .o_result(o_result), .o_result_valid(o_result_valid),
    .o_error(o_error)
  );

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic [7:0]   sbox [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] rk [16];
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      if (i != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gm(inv, 8'(i));
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[i] = s;
      inv_sbox[s] = 8'(i);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Round behaviour selected by round type: 0 key add, 1 full inverse round, 2 round without mix, 3 pass.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [1:0] t, input logic [127:0] key);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] o;
    if (t == 2'd0) return s ^ key;
    if (t == 2'd3) return s;
    for (int i = 0; i < 16; i++) a[i] = s[127 - 8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r + 4*c] = inv_sbox[a[r + 4*((c - r + 4) % 4)]];
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = b[i];
    o = o ^ key;
    if (t == 2'd1) begin
      for (int i = 0; i < 16; i++) a[i] = o[127 - 8*i -: 8];
      for (int c = 0; c < 4; c++) begin
        b[4*c]   = gm(a[4*c],8'd14) ^ gm(a[4*c+1],8'd11) ^ gm(a[4*c+2],8'd13) ^ gm(a[4*c+3],8'd9);
        b[4*c+1] = gm(a[4*c],8'd9)  ^ gm(a[4*c+1],8'd14) ^ gm(a[4*c+2],8'd11) ^ gm(a[4*c+3],8'd13);
        b[4*c+2] = gm(a[4*c],8'd13) ^ gm(a[4*c+1],8'd9)  ^ gm(a[4*c+2],8'd14) ^ gm(a[4*c+3],8'd11);
        b[4*c+3] = gm(a[4*c],8'd11) ^ gm(a[4*c+1],8'd13) ^ gm(a[4*c+2],8'd9)  ^ gm(a[4*c+3],8'd14);
      end
      for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = b[i];
    end
    return o;
  endfunction

  function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input int nr);
    logic [127:0] s;
    s = ct ^ rk[nr];
    for (int r = nr - 1; r >= 1; r--) s = inv_round(s, 2'd1, rk[r]);
    return inv_round(s, 2'd2, rk[0]);
  endfunction

  always_comb i_dp_new_block = inv_round(o_dp_block, o_round_type, rk[o_round_key_addr]);

  task automatic run_block(input string name, input logic [127:0] ct, input logic [1:0] kl,
                           input logic [127:0] exp_pt, input bit chk_seq, input bit noise, input bit abort_start);
    int nr, n;
    logic [1:0] tq [$];
    logic [3:0] aq [$];
    logic [1:0] et;
    logic [3:0] ea;
    nr = 10 + 2*int'(kl);
    i_block = ct; i_keylen = kl; i_key_ready = 1'b1; i_next = 1'b1; i_abort = abort_start;
    @(posedge clk); #1;
    i_next = 1'b0; i_abort = 1'b0;
    checks++;
    if (o_ready !== 1'b0) begin errors++; $display("FAIL %s accept: ready=%0b required 0", name, o_ready); end
    n = 0;
    while (!o_result_valid && n < 40) begin
      tq.push_back(o_round_type); aq.push_back(o_round_key_addr);
      if (noise) begin
        i_next = 1'($urandom_range(0, 1)); i_keylen = 2'($urandom_range(0, 3)); i_key_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      n++;
    end
    i_next = 1'b0; i_keylen = kl; i_key_ready = 1'b1;
    checks++;
    if (n !== nr + 1) begin errors++; $display("FAIL %s latency: got %0d edges required %0d", name, n, nr + 1); end
    checks++;
    if (o_result !== exp_pt) begin errors++; $display("FAIL %s result: got %h required %h", name, o_result, exp_pt); end
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL %s ready at valid: got %0b required 1", name, o_ready); end
    if (chk_seq) begin
      for (int j = 0; j <= nr && j < tq.size(); j++) begin
        et = (j == 0) ? 2'd0 : (j == nr) ? 2'd2 : 2'd1;
        ea = (j == 0) ? 4'(nr) : (j == nr) ? 4'd0 : 4'(nr - j);
        checks++;
        if (tq[j] !== et || aq[j] !== ea) begin
          errors++;
          $display("FAIL %s round %0d: type=%0d addr=%0d required type=%0d addr=%0d", name, j, tq[j], aq[j], et, ea);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (o_result_valid !== 1'b0 || o_result !== exp_pt) begin
      errors++; $display("FAIL %s after pulse: valid=%0b result=%h required 0 and %h", name, o_result_valid, o_result, exp_pt);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_next = 1'b0; i_abort = 1'b0; i_keylen = 2'd0; i_key_ready = 1'b1; i_block = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_round_type !== 2'd3 || o_round_key_addr !== 4'd0 || o_result !== '0 ||
        o_result_valid !== 1'b0 || o_error !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%0b type=%0d addr=%0d result=%h valid=%0b err=%0b required 1 3 0 0 0 0",
               o_ready, o_round_type, o_round_key_addr, o_result, o_result_valid, o_error);
    end
    i_reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_known_vectors();
    expand(KEY128, 10); run_block("aes128", CT128, 2'd0, PT, 1'b1, 1'b0, 1'b0);
    expand(KEY192, 12); run_block("aes192", CT192, 2'd1, PT, 1'b1, 1'b0, 1'b0);
    expand(KEY256, 14); run_block("aes256", CT256, 2'd2, PT, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [255:0] key;
    logic [127:0] ct;
    logic [1:0]   kl;
    for (int it = 0; it < 6; it++) begin
      key = '0;
      for (int i = 0; i < 8; i++) key = {key[223:0], 32'($urandom)};
      ct = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      kl = 2'($urandom_range(0, 2));
      expand(key, 10 + 2*int'(kl));
      run_block("random", ct, kl, model_decrypt(ct, 10 + 2*int'(kl)), 1'b1, 1'b0, 1'b0);
    end
    expand(KEY128, 10);
  endtask

  task automatic test_back_to_back();
    int pulses [$];
    int cyc, w;
    i_block = CT128; i_keylen = 2'd0; i_key_ready = 1'b1; i_next = 1'b1;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (o_result_valid) begin
        pulses.push_back(cyc);
        checks++;
        if (o_result !== PT) begin errors++; $display("FAIL b2b result: got %h required %h", o_result, PT); end
      end
    end
    i_next = 1'b0;
    checks++;
    if (pulses.size() !== 5) begin errors++; $display("FAIL b2b pulse count: got %0d required 5", pulses.size()); end
    for (int j = 0; j < pulses.size(); j++) begin
      checks++;
      if (pulses[j] !== 12 * (j + 1)) begin
        errors++; $display("FAIL b2b pulse %0d: at cycle %0d required %0d", j, pulses[j], 12 * (j + 1));
      end
    end
    w = 0;
    while (!o_result_valid && w < 20) begin @(posedge clk); #1; w++; end
    checks++;
    if (o_result_valid !== 1'b1) begin errors++; $display("FAIL b2b drain: valid=%0b required 1", o_result_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    for (int k = 0; k < 2; k++) begin
      i_keylen = (k == 0) ? 2'd3 : 2'd0;
      i_key_ready = (k == 0) ? 1'b1 : 1'b0;
      i_block = 128'hdeadbeef; i_next = 1'b1;
      @(posedge clk); #1;
      i_next = 1'b0;
      checks++;
      if (o_error !== 1'b1 || o_ready !== 1'b1 || o_result !== PT) begin
        errors++; $display("FAIL illegal%0d pulse: err=%0b ready=%0b result=%h required 1 1 %h", k, o_error, o_ready, o_result, PT);
      end
      @(posedge clk); #1;
      checks++;
      if (o_error !== 1'b0 || o_ready !== 1'b1) begin
        errors++; $display("FAIL illegal%0d after: err=%0b ready=%0b required 0 1", k, o_error, o_ready);
      end
    end
    i_keylen = 2'd0; i_key_ready = 1'b1;
  endtask

  task automatic test_abort();
    int w, rv;
    bit found;
    i_block = CT128; i_keylen = 2'd0; i_next = 1'b1;
    @(posedge clk); #1;
    i_next = 1'b0;
    w = 0; found = 1'b0;
    while (!found && w < 20) begin
      if (o_round_type == 2'd1 && o_round_key_addr == 4'd5) found = 1'b1;
      else begin @(posedge clk); #1; w++; end
    end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL abort reach: found=%0b required 1", found); end
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_round_type !== 2'd3 || o_round_key_addr !== 4'd0 || o_result_valid !== 1'b0) begin
      errors++; $display("FAIL abort idle: ready=%0b type=%0d addr=%0d valid=%0b required 1 3 0 0",
                         o_ready, o_round_type, o_round_key_addr, o_result_valid);
    end
    rv = 0;
    repeat (15) begin @(posedge clk); #1; if (o_result_valid) rv++; end
    checks++;
    if (rv !== 0) begin errors++; $display("FAIL abort no valid: got %0d pulses required 0", rv); end
    run_block("after_abort", CT128, 2'd0, PT, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    i_block = CT128; i_keylen = 2'd0; i_next = 1'b1;
    @(posedge clk); #1;
    i_next = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_round_type !== 2'd3 || o_round_key_addr !== 4'd0 || o_result !== '0 ||
        o_dp_block !== '0 || o_result_valid !== 1'b0 || o_error !== 1'b0) begin
      errors++; $display("FAIL reset mid: ready=%0b type=%0d addr=%0d result=%h valid=%0b err=%0b required 1 3 0 0 0 0",
                         o_ready, o_round_type, o_round_key_addr, o_result, o_result_valid, o_error);
    end
    run_block("after_reset", CT128, 2'd0, PT, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_simultaneous();
    run_block("next_abort_idle", CT128, 2'd0, PT, 1'b1, 1'b0, 1'b1);
    run_block("keylen_noise", CT128, 2'd0, PT, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_known_vectors();
    test_random();
    test_back_to_back();
    test_illegal();
    test_abort();
    test_reset_mid();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
